// File: rtl/kip_router_mc.sv
// kip_router_mc: round-robin, packet-granular router merging NUM_INPUTS
// kernel AXIS streams into the rx_nb (local) and GULF-Stream (remote) outputs.
//
// Ports:
//   i_clk, i_ap_rst          clock, synchronous active-high reset
//   i_local_ip_address       local IP, compared only when a packet is granted
//   from_kernels_*           NUM_INPUTS packed AXIS slave streams (input i at slice i)
//   to_rx_nb_*               registered AXIS master for locally addressed packets
//   to_gs_*                  registered AXIS master for remote packets
//   o_pkt_count_local/remote packets (tlast beats) loaded into each output

module kip_router_mc #(
    parameter int NUM_INPUTS           = 4,
    parameter int AXIS_DATA_WIDTH      = 512,
    parameter int AXIS_KEEP_WIDTH      = 64,
    parameter int AXIS_KIP_TUSER_WIDTH = 64,
    parameter int IP_ADDRESS_WIDTH     = 32,
    parameter bit BROADCAST_EN         = 1'b1
) (
    input  logic                                       i_clk,
    input  logic                                       i_ap_rst,
    input  logic [IP_ADDRESS_WIDTH-1:0]                i_local_ip_address,

    input  logic [NUM_INPUTS-1:0]                      from_kernels_tvalid,
    output logic [NUM_INPUTS-1:0]                      from_kernels_tready,
    input  logic [NUM_INPUTS-1:0]                      from_kernels_tlast,
    input  logic [NUM_INPUTS*AXIS_DATA_WIDTH-1:0]      from_kernels_tdata,
    input  logic [NUM_INPUTS*AXIS_KEEP_WIDTH-1:0]      from_kernels_tkeep,
    input  logic [NUM_INPUTS*AXIS_KIP_TUSER_WIDTH-1:0] from_kernels_tuser,

    output logic                                       to_rx_nb_tvalid,
    input  logic                                       to_rx_nb_tready,
    output logic [AXIS_DATA_WIDTH-1:0]                 to_rx_nb_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]                 to_rx_nb_tkeep,
    output logic [AXIS_KIP_TUSER_WIDTH-1:0]            to_rx_nb_tuser,
    output logic                                       to_rx_nb_tlast,

    output logic                                       to_gs_tvalid,
    input  logic                                       to_gs_tready,
    output logic [AXIS_DATA_WIDTH-1:0]                 to_gs_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]                 to_gs_tkeep,
    output logic [AXIS_KIP_TUSER_WIDTH-1:0]            to_gs_tuser,
    output logic                                       to_gs_tlast,

    output logic [31:0]                                o_pkt_count_local,
    output logic [31:0]                                o_pkt_count_remote
);

    localparam int DW  = AXIS_DATA_WIDTH;
    localparam int KW  = AXIS_KEEP_WIDTH;
    localparam int UW  = AXIS_KIP_TUSER_WIDTH;
    localparam int IPW = IP_ADDRESS_WIDTH;
    localparam int GW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic            route_local_q, route_local_d;
    logic            route_remote_q, route_remote_d;

    logic            rx_valid_q;
    logic [DW-1:0]   rx_data_q;
    logic [KW-1:0]   rx_keep_q;
    logic [UW-1:0]   rx_user_q;
    logic            rx_last_q;

    logic            gs_valid_q;
    logic [DW-1:0]   gs_data_q;
    logic [KW-1:0]   gs_keep_q;
    logic [UW-1:0]   gs_user_q;
    logic            gs_last_q;

    logic [31:0]     cnt_local_q;
    logic [31:0]     cnt_remote_q;

    // Currently granted input stream
    logic            sel_valid;
    logic            sel_last;
    logic [DW-1:0]   sel_data;
    logic [KW-1:0]   sel_keep;
    logic [UW-1:0]   sel_user;

    assign sel_valid = from_kernels_tvalid[grant_q];
    assign sel_last  = from_kernels_tlast[grant_q];
    assign sel_data  = from_kernels_tdata[int'(grant_q)*DW +: DW];
    assign sel_keep  = from_kernels_tkeep[int'(grant_q)*KW +: KW];
    assign sel_user  = from_kernels_tuser[int'(grant_q)*UW +: UW];

    // Round-robin search starting just after the previous winner
    logic [GW-1:0]   pick;
    logic            found;
    int              idx;

    always_comb begin
        pick  = last_grant_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_INPUTS;
            if (!found && from_kernels_tvalid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    logic [IPW-1:0]  pick_ip;
    logic            dest_local;
    logic            dest_bcast;

    assign pick_ip    = from_kernels_tuser[int'(pick)*UW +: IPW];
    assign dest_local = (pick_ip == i_local_ip_address);
    assign dest_bcast = BROADCAST_EN && (&pick_ip);

    // A beat may move only if every targeted register is free or
    // emptying this cycle; for BOTH this holds the beat until both can take it.
    logic            can_take;
    logic            accept;

    assign can_take = (!route_local_q  || !rx_valid_q || to_rx_nb_tready) &&
                      (!route_remote_q || !gs_valid_q || to_gs_tready);

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        last_grant_d        = last_grant_q;
        route_local_d       = route_local_q;
        route_remote_d      = route_remote_q;
        from_kernels_tready = '0;
        accept              = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|from_kernels_tvalid) begin
                    grant_d        = pick;
                    route_local_d  = dest_local || dest_bcast;
                    route_remote_d = !dest_local;
                    state_d        = LOCKED;
                end
            end
            LOCKED: begin
                from_kernels_tready[grant_q] = can_take;
                accept = can_take && sel_valid;
                if (accept && sel_last) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_ap_rst) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            last_grant_q   <= GW'(NUM_INPUTS - 1);
            route_local_q  <= 1'b0;
            route_remote_q <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
            rx_keep_q      <= '0;
            rx_user_q      <= '0;
            rx_last_q      <= 1'b0;
            gs_valid_q     <= 1'b0;
            gs_data_q      <= '0;
            gs_keep_q      <= '0;
            gs_user_q      <= '0;
            gs_last_q      <= 1'b0;
            cnt_local_q    <= '0;
            cnt_remote_q   <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            route_local_q  <= route_local_d;
            route_remote_q <= route_remote_d;

            if (accept && route_local_q) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= sel_data;
                rx_keep_q  <= sel_keep;
                rx_user_q  <= sel_user;
                rx_last_q  <= sel_last;
            end else if (to_rx_nb_tready) begin
                rx_valid_q <= 1'b0;
            end

            if (accept && route_remote_q) begin
                gs_valid_q <= 1'b1;
                gs_data_q  <= sel_data;
                gs_keep_q  <= sel_keep;
                gs_user_q  <= sel_user;
                gs_last_q  <= sel_last;
            end else if (to_gs_tready) begin
                gs_valid_q <= 1'b0;
            end

            if (accept && sel_last && route_local_q)
                cnt_local_q <= cnt_local_q + 32'd1;
            if (accept && sel_last && route_remote_q)
                cnt_remote_q <= cnt_remote_q + 32'd1;
        end
    end

    assign to_rx_nb_tvalid    = rx_valid_q;
    assign to_rx_nb_tdata     = rx_data_q;
    assign to_rx_nb_tkeep     = rx_keep_q;
    assign to_rx_nb_tuser     = rx_user_q;
    assign to_rx_nb_tlast     = rx_last_q;

    assign to_gs_tvalid       = gs_valid_q;
    assign to_gs_tdata        = gs_data_q;
    assign to_gs_tkeep        = gs_keep_q;
    assign to_gs_tuser        = gs_user_q;
    assign to_gs_tlast        = gs_last_q;

    assign o_pkt_count_local  = cnt_local_q;
    assign o_pkt_count_remote = cnt_remote_q;

endmodule

// File: tb/tb_kip_router_mc.sv
// tb_kip_router_mc: directed bench for kip_router_mc with a packet-level
// scoreboard model and hand-computed literal expectations.

module tb_kip_router_mc;

    localparam int N   = 4;
    localparam int DW  = 512;
    localparam int KW  = 64;
    localparam int UW  = 64;
    localparam int IPW = 32;

    logic              clk = 1'b0;
    logic              i_ap_rst = 1'b1;
    logic [IPW-1:0]    i_local_ip_address;
    logic [N-1:0]      from_kernels_tvalid;
    logic [N-1:0]      from_kernels_tready;
    logic [N-1:0]      from_kernels_tlast;
    logic [N*DW-1:0]   from_kernels_tdata;
    logic [N*KW-1:0]   from_kernels_tkeep;
    logic [N*UW-1:0]   from_kernels_tuser;
    logic              to_rx_nb_tvalid, to_rx_nb_tready, to_rx_nb_tlast;
    logic [DW-1:0]     to_rx_nb_tdata;
    logic [KW-1:0]     to_rx_nb_tkeep;
    logic [UW-1:0]     to_rx_nb_tuser;
    logic              to_gs_tvalid, to_gs_tready, to_gs_tlast;
    logic [DW-1:0]     to_gs_tdata;
    logic [KW-1:0]     to_gs_tkeep;
    logic [UW-1:0]     to_gs_tuser;
    logic [31:0]       o_pkt_count_local, o_pkt_count_remote;

    always #5 clk = ~clk;

    kip_router_mc #(
        .NUM_INPUTS(N), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW),
        .AXIS_KIP_TUSER_WIDTH(UW), .IP_ADDRESS_WIDTH(IPW), .BROADCAST_EN(1'b1)
    ) dut (
        .i_clk(clk), .i_ap_rst(i_ap_rst), .i_local_ip_address(i_local_ip_address),
        .from_kernels_tvalid(from_kernels_tvalid), .from_kernels_tready(from_kernels_tready),
        .from_kernels_tlast(from_kernels_tlast), .from_kernels_tdata(from_kernels_tdata),
        .from_kernels_tkeep(from_kernels_tkeep), .from_kernels_tuser(from_kernels_tuser),
        .to_rx_nb_tvalid(to_rx_nb_tvalid), .to_rx_nb_tready(to_rx_nb_tready),
        .to_rx_nb_tdata(to_rx_nb_tdata), .to_rx_nb_tkeep(to_rx_nb_tkeep),
        .to_rx_nb_tuser(to_rx_nb_tuser), .to_rx_nb_tlast(to_rx_nb_tlast),
        .to_gs_tvalid(to_gs_tvalid), .to_gs_tready(to_gs_tready),
        .to_gs_tdata(to_gs_tdata), .to_gs_tkeep(to_gs_tkeep),
        .to_gs_tuser(to_gs_tuser), .to_gs_tlast(to_gs_tlast),
        .o_pkt_count_local(o_pkt_count_local), .o_pkt_count_remote(o_pkt_count_remote)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t       inq[N][$];
    beat_t       exp_rx[$];
    beat_t       exp_gs[$];
    int          grant_log[$];
    int          sop_cyc[$];
    int          eop_cyc[$];
    int          errors = 0;
    int          checks = 0;
    int          rx_pops = 0;
    int          gs_pops = 0;
    int          mcyc = 0;
    int          pkt_id = 0;
    logic [31:0] m_cnt_l = '0;
    logic [31:0] m_cnt_r = '0;

    int          rx_block = 0;
    int          gs_block = 0;
    int          ip_chg_cyc = 0;
    logic [31:0] ip_new = '0;
    int          rst_after = 0;
    int          rst_beats = 0;
    int          post_rst = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int rr(input logic [N-1:0] v, input int last);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return last;
    endfunction

    task automatic add_pkt(input int src, input int nb, input logic [63:0] u0, input logic [63:0] un);
        beat_t b;
        for (int j = 0; j < nb; j++) begin
            b.data = '0;
            for (int w = 0; w < DW / 32; w++)
                b.data[w*32 +: 32] = {8'(src), 8'(pkt_id), 8'(j), 8'(w)};
            b.keep = {32'hFFFF_FFFF, 24'h0, 8'(pkt_id * 3 + j)};
            b.user = (j == 0) ? u0 : un;
            b.last = (j == nb - 1);
            inq[src].push_back(b);
        end
        pkt_id++;
    endtask

    // One clock of stimulus: observe handshakes at negedge, update after posedge.
    task automatic step();
        logic [N-1:0] fire;
        beat_t        b;
        @(negedge clk);
        fire = from_kernels_tvalid & from_kernels_tready;
        if (post_rst == 1) begin
            chk("rst_tready", from_kernels_tready, '0);
            chk("rst_rx_valid", to_rx_nb_tvalid, 0);
            chk("rst_gs_valid", to_gs_tvalid, 0);
            chk("rst_cnt_local", o_pkt_count_local, 0);
            chk("rst_cnt_remote", o_pkt_count_remote, 0);
        end
        if (post_rst > 0) post_rst--;
        @(posedge clk);
        #1;
        i_ap_rst = 1'b0;
        for (int i = 0; i < N; i++)
            if (fire[i] && inq[i].size() > 0) void'(inq[i].pop_front());
        if (rst_after > 0 && fire[0]) begin
            rst_beats++;
            if (rst_beats == rst_after) begin
                rst_after = 0;
                i_ap_rst  = 1'b1;
                post_rst  = 2;
                for (int i = 0; i < N; i++) inq[i].delete();
            end
        end
        to_rx_nb_tready = (rx_block == 0);
        if (rx_block > 0) rx_block--;
        to_gs_tready = (gs_block == 0);
        if (gs_block > 0) gs_block--;
        if (ip_chg_cyc > 0) begin
            ip_chg_cyc--;
            if (ip_chg_cyc == 0) i_local_ip_address = ip_new;
        end
        for (int i = 0; i < N; i++) begin
            if (inq[i].size() > 0) begin
                b = inq[i][0];
                from_kernels_tvalid[i]         = 1'b1;
                from_kernels_tdata[i*DW +: DW] = b.data;
                from_kernels_tkeep[i*KW +: KW] = b.keep;
                from_kernels_tuser[i*UW +: UW] = b.user;
                from_kernels_tlast[i]          = b.last;
            end else begin
                from_kernels_tvalid[i]         = 1'b0;
                from_kernels_tdata[i*DW +: DW] = '0;
                from_kernels_tkeep[i*KW +: KW] = '0;
                from_kernels_tuser[i*UW +: UW] = '0;
                from_kernels_tlast[i]          = 1'b0;
            end
        end
    endtask

    task automatic run_until(input string name);
        int  n;
        logic busy;
        n = 0;
        do begin
            step();
            n++;
            busy = 1'b0;
            for (int i = 0; i < N; i++) if (inq[i].size() > 0) busy = 1'b1;
            if (exp_rx.size() > 0 || exp_gs.size() > 0) busy = 1'b1;
            if (to_rx_nb_tvalid || to_gs_tvalid || i_ap_rst || post_rst > 0) busy = 1'b1;
        end while (busy && n < 400);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy after %0d cycles want idle", name, n);
        end
        step();
        step();
    endtask

    // Packet-level reference model and per-cycle compare
    initial begin : monitor
        int          m_phase, m_grant, m_last;
        logic        m_l, m_r, m_sop, occ_rx, occ_gs, ok;
        logic        p_rxv, p_rxr, p_gsv, p_gsr;
        beat_t       p_rx, p_gs, e;
        logic [N-1:0] exp_t, one;
        logic [IPW-1:0] ip;
        m_phase = 0; m_grant = 0; m_last = N - 1;
        m_l = 0; m_r = 0; m_sop = 0;
        p_rxv = 0; p_rxr = 0; p_gsv = 0; p_gsr = 0;
        one = 1;
        forever begin
            @(negedge clk);
            mcyc++;
            chk("cnt_local", o_pkt_count_local, m_cnt_l);
            chk("cnt_remote", o_pkt_count_remote, m_cnt_r);
            if (i_ap_rst) begin
                exp_rx.delete();
                exp_gs.delete();
                m_phase = 0;
                m_last  = N - 1;
                m_cnt_l = '0;
                m_cnt_r = '0;
                p_rxv   = 0;
                p_gsv   = 0;
                continue;
            end
            if (p_rxv && !p_rxr) begin
                chk("rx_hold_valid", to_rx_nb_tvalid, 1);
                chk("rx_hold_data", to_rx_nb_tdata, p_rx.data);
                chk("rx_hold_user", to_rx_nb_tuser, p_rx.user);
            end
            if (p_gsv && !p_gsr) begin
                chk("gs_hold_valid", to_gs_tvalid, 1);
                chk("gs_hold_data", to_gs_tdata, p_gs.data);
                chk("gs_hold_user", to_gs_tuser, p_gs.user);
            end
            occ_rx = exp_rx.size() != 0;
            occ_gs = exp_gs.size() != 0;
            chk("rx_valid", to_rx_nb_tvalid, occ_rx);
            chk("gs_valid", to_gs_tvalid, occ_gs);
            if (to_rx_nb_tvalid && to_rx_nb_tready && occ_rx) begin
                e = exp_rx.pop_front();
                chk("rx_data", to_rx_nb_tdata, e.data);
                chk("rx_keep", to_rx_nb_tkeep, e.keep);
                chk("rx_user", to_rx_nb_tuser, e.user);
                chk("rx_last", to_rx_nb_tlast, e.last);
                rx_pops++;
            end
            if (to_gs_tvalid && to_gs_tready && occ_gs) begin
                e = exp_gs.pop_front();
                chk("gs_data", to_gs_tdata, e.data);
                chk("gs_keep", to_gs_tkeep, e.keep);
                chk("gs_user", to_gs_tuser, e.user);
                chk("gs_last", to_gs_tlast, e.last);
                gs_pops++;
            end
            p_rxv = to_rx_nb_tvalid; p_rxr = to_rx_nb_tready;
            p_rx.data = to_rx_nb_tdata; p_rx.user = to_rx_nb_tuser;
            p_gsv = to_gs_tvalid; p_gsr = to_gs_tready;
            p_gs.data = to_gs_tdata; p_gs.user = to_gs_tuser;

            if (m_phase == 0) begin
                chk("tready_idle", from_kernels_tready, '0);
                if (|from_kernels_tvalid) begin
                    m_grant = rr(from_kernels_tvalid, m_last);
                    ip      = from_kernels_tuser[m_grant*UW +: IPW];
                    m_l     = (ip == i_local_ip_address) || (&ip);
                    m_r     = (ip != i_local_ip_address);
                    m_phase = 1;
                    m_sop   = 1;
                end
            end else begin
                ok    = (!m_l || !occ_rx || to_rx_nb_tready) && (!m_r || !occ_gs || to_gs_tready);
                exp_t = ok ? (one << m_grant) : '0;
                chk("tready", from_kernels_tready, exp_t);
                if (from_kernels_tvalid[m_grant] && from_kernels_tready[m_grant]) begin
                    e.data = from_kernels_tdata[m_grant*DW +: DW];
                    e.keep = from_kernels_tkeep[m_grant*KW +: KW];
                    e.user = from_kernels_tuser[m_grant*UW +: UW];
                    e.last = from_kernels_tlast[m_grant];
                    if (m_l) exp_rx.push_back(e);
                    if (m_r) exp_gs.push_back(e);
                    if (m_sop) begin
                        grant_log.push_back(m_grant);
                        sop_cyc.push_back(mcyc);
                        m_sop = 0;
                    end
                    if (e.last) begin
                        m_phase = 0;
                        m_last  = m_grant;
                        eop_cyc.push_back(mcyc);
                        if (m_l) m_cnt_l = m_cnt_l + 1;
                        if (m_r) m_cnt_r = m_cnt_r + 1;
                    end
                end
            end
        end
    end

    initial begin : stim
        int r0, g0, b0, l0, q0;
        int exp_order[6];
        exp_order = '{0, 1, 2, 0, 1, 2};
        i_local_ip_address  = 32'h0A03_0705;
        to_rx_nb_tready     = 1'b1;
        to_gs_tready        = 1'b1;
        from_kernels_tvalid = '0;
        from_kernels_tlast  = '0;
        from_kernels_tdata  = '0;
        from_kernels_tkeep  = '0;
        from_kernels_tuser  = '0;
        repeat (3) @(posedge clk);
        #1;
        i_ap_rst = 1'b0;
        @(negedge clk);
        chk("reset_tready", from_kernels_tready, '0);
        chk("reset_rx_valid", to_rx_nb_tvalid, 0);
        chk("reset_gs_valid", to_gs_tvalid, 0);
        chk("reset_rx_data", to_rx_nb_tdata, '0);
        chk("reset_cnt_local", o_pkt_count_local, 0);
        chk("reset_cnt_remote", o_pkt_count_remote, 0);

        // Local route
        r0 = rx_pops; g0 = gs_pops;
        add_pkt(0, 3, 64'hABABCDCD0A030705, 64'hABABCDCD0A030705);
        run_until("local");
        chk("local_beats", rx_pops - r0, 3);
        chk("local_gs_beats", gs_pops - g0, 0);
        chk("local_cnt", o_pkt_count_local, 1);
        chk("local_cnt_remote", o_pkt_count_remote, 0);

        // Remote route with gs backpressure
        g0 = gs_pops;
        add_pkt(3, 3, 64'hFEFECDCD12121212, 64'hFEFECDCD12121212);
        gs_block = 5;
        repeat (4) step();
        chk("bp_gs_valid", to_gs_tvalid, 1);
        chk("bp_gs_word0", to_gs_tdata[31:0], 32'h0301_0000);
        chk("bp_in_tready", from_kernels_tready, '0);
        run_until("remote");
        chk("remote_beats", gs_pops - g0, 3);
        chk("remote_cnt", o_pkt_count_remote, 1);

        // Round-robin over inputs 0,1,2
        q0 = grant_log.size();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < 3; s++)
                add_pkt(s, 2, (s == 1) ? 64'h0000_0001_0A03_0705 : 64'h0000_0002_1212_1212,
                        64'h0000_0003_0000_0000);
        run_until("rr");
        chk("rr_pkts", grant_log.size() - q0, 6);
        if (grant_log.size() - q0 == 6 && eop_cyc.size() - q0 == 6) begin
            for (int k = 0; k < 6; k++)
                chk("rr_order", grant_log[q0 + k], exp_order[k]);
            for (int k = 0; k < 5; k++)
                chk("rr_gap", sop_cyc[q0 + k + 1] - eop_cyc[q0 + k], 2);
        end

        // Broadcast with rx backpressure
        l0 = o_pkt_count_local; b0 = o_pkt_count_remote;
        r0 = rx_pops; g0 = gs_pops;
        add_pkt(1, 2, 64'h5A5A5A5A_FFFFFFFF, 64'h5A5A5A5A_FFFFFFFF);
        rx_block = 3;
        run_until("bcast");
        chk("bcast_cnt_local", o_pkt_count_local - l0, 1);
        chk("bcast_cnt_remote", o_pkt_count_remote - b0, 1);
        chk("bcast_rx_beats", rx_pops - r0, 2);
        chk("bcast_gs_beats", gs_pops - g0, 2);

        // Route locked at SOP despite IP and tuser changes
        l0 = o_pkt_count_local;
        r0 = rx_pops; g0 = gs_pops;
        add_pkt(2, 4, 64'h0000_0004_0A03_0705, 64'h0000_0005_1212_1212);
        ip_new = 32'h0B0B_0B0B;
        ip_chg_cyc = 3;
        run_until("lock");
        chk("lock_rx_beats", rx_pops - r0, 4);
        chk("lock_gs_beats", gs_pops - g0, 0);
        chk("lock_cnt_local", o_pkt_count_local - l0, 1);
        i_local_ip_address = 32'h0A03_0705;

        // Reset after beat 2 of a 4-beat packet
        add_pkt(0, 4, 64'h0000_0006_0A03_0705, 64'h0000_0006_0A03_0705);
        rst_beats = 0;
        rst_after = 2;
        run_until("rst_mid");
        g0 = gs_pops;
        add_pkt(1, 2, 64'h0000_0007_1212_1212, 64'h0000_0007_1212_1212);
        run_until("post_rst");
        chk("post_rst_gs_beats", gs_pops - g0, 2);
        chk("post_rst_cnt_remote", o_pkt_count_remote, 1);
        chk("post_rst_cnt_local", o_pkt_count_local, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
